// File: rtl/qbert_move_input_if.sv
// Move request handshake between the button conditioner and the game-state block.
// The conditioner drives move_valid/move_dir; the consumer answers with move_ready.
interface qbert_move_input_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/qbert_move_input.sv
// Debounces the four active-low jump buttons and issues one move per press with a cooldown.
// Optional build macro MOVE_QUEUE_EN adds a one-deep queue for presses arriving while busy.
//
// state    | meaning
// S_IDLE   | waiting for a press pulse
// S_ISSUE  | move_valid held with a stable move_dir until move_ready
// S_COOL   | cooldown after an accepted move; new presses not issued
module qbert_move_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_CYCLES = 2500000
) (
  input  logic                 clk_25,
  input  logic                 rst_n,
  input  logic                 button1,
  input  logic                 button2,
  input  logic                 button3,
  input  logic                 button4,
  qbert_move_input_if.master   move_if,
  output logic [3:0]           btn_level,
  output logic                 busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    prev_q;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    press;

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [CW-1:0] cd_cnt_q, cd_cnt_d;
  logic          cool_done;
  logic          move_valid_o;
  logic          busy_o;

`ifdef MOVE_QUEUE_EN
  logic          qv_q, qv_d;
  logic [1:0]    qdir_q, qdir_d;
`endif

  assign raw = {button4, button3, button2, button1};

  function automatic logic [1:0] lowest_idx(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Synchronizer, debounced level and its one-cycle-old copy for edge detection.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      stable_q <= 4'hF;
      prev_q   <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Only the released-to-pressed transition makes a request.
  assign press     = prev_q & ~stable_q;
  assign btn_level = stable_q;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= 2'd0;
      cd_cnt_q <= '0;
`ifdef MOVE_QUEUE_EN
      qv_q     <= 1'b0;
      qdir_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cd_cnt_q <= cd_cnt_d;
`ifdef MOVE_QUEUE_EN
      qv_q     <= qv_d;
      qdir_q   <= qdir_d;
`endif
    end
  end

  assign cool_done = (state_q == S_COOL) && (cd_cnt_q == CD_LAST);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cd_cnt_d = cd_cnt_q;
`ifdef MOVE_QUEUE_EN
    qv_d     = qv_q;
    qdir_d   = qdir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|press) begin
          state_d = S_ISSUE;
          dir_d   = lowest_idx(press);
        end
      end
      S_ISSUE: begin
        if (move_if.move_ready) begin
          state_d  = S_COOL;
          cd_cnt_d = '0;
        end
      end
      S_COOL: begin
        if (cool_done) begin
          state_d  = S_IDLE;
          cd_cnt_d = '0;
`ifdef MOVE_QUEUE_EN
          // A press landing on the exit cycle is issued directly rather than parked.
          if (qv_q) begin
            state_d = S_ISSUE;
            dir_d   = qdir_q;
            qv_d    = 1'b0;
          end else if (|press) begin
            state_d = S_ISSUE;
            dir_d   = lowest_idx(press);
          end
`endif
        end else begin
          cd_cnt_d = cd_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        cd_cnt_d = '0;
      end
    endcase
`ifdef MOVE_QUEUE_EN
    if ((state_q != S_IDLE) && !cool_done && (|press) && !qv_q) begin
      qv_d   = 1'b1;
      qdir_d = lowest_idx(press);
    end
`endif
  end

  always_comb begin
    move_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      S_ISSUE: begin
        move_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_COOL:  busy_o = 1'b1;
      default: begin
        move_valid_o = 1'b0;
        busy_o       = 1'b0;
      end
    endcase
  end

  assign move_if.move_valid = move_valid_o;
  assign move_if.move_dir   = dir_q;
  assign busy               = busy_o;

endmodule

// File: tb/tb_qbert_move_input.sv
// Directed bench for qbert_move_input with a cycle-level behavioural model and literal checks.
module tb_qbert_move_input;
  localparam int D = 4;
  localparam int C = 8;

  logic       clk_25;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] btn_level;
  logic       busy;

  qbert_move_input_if mif ();

  qbert_move_input #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
    .clk_25   (clk_25),
    .rst_n    (rst_n),
    .button1  (raw[0]),
    .button2  (raw[1]),
    .button3  (raw[2]),
    .button4  (raw[3]),
    .move_if  (mif),
    .btn_level(btn_level),
    .busy     (busy)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  int vectors = 0;
  int fails   = 0;
  int cnt_valid = 0;
  int cnt_busy  = 0;
  int cnt_lvl0  = 0;
  int last_dir  = -1;

  // Model state: raw samples delayed through the two synchronizer stages,
  // per-button disagreement run length, pending move and cooldown cycles left.
  logic [3:0] m_r1 = 4'hF, m_r2 = 4'hF, m_stable = 4'hF, m_press = 4'h0, m_new;
  int         m_run [4] = '{0, 0, 0, 0};
  bit         m_pend = 0;
  int         m_dir  = 0;
  int         m_cool = 0;
  bit         m_qv   = 0;
  int         m_qd   = 0;
  bit         m_busy_b, m_exit;

  function automatic int first_pressed(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  always @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      m_r1 = 4'hF; m_r2 = 4'hF; m_stable = 4'hF; m_press = 4'h0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_pend = 0; m_dir = 0; m_cool = 0; m_qv = 0; m_qd = 0;
    end else begin
      m_busy_b = m_pend || (m_cool > 0);
      m_exit   = !m_pend && (m_cool == 1);
      if (m_pend) begin
        if (mif.move_ready) begin
          m_pend = 0;
          m_cool = C;
        end
      end else if (m_cool > 0) begin
        m_cool = m_cool - 1;
`ifdef MOVE_QUEUE_EN
        if (m_cool == 0) begin
          if (m_qv) begin
            m_pend = 1; m_dir = m_qd; m_qv = 0;
          end else if (m_press != 0) begin
            m_pend = 1; m_dir = first_pressed(m_press);
          end
        end
`endif
      end else if (m_press != 0) begin
        m_pend = 1;
        m_dir  = first_pressed(m_press);
      end
`ifdef MOVE_QUEUE_EN
      if (m_busy_b && !m_exit && m_press != 0 && !m_qv) begin
        m_qv = 1; m_qd = first_pressed(m_press);
      end
`endif
      m_new = m_stable;
      for (int i = 0; i < 4; i++) begin
        if (m_r2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_new[i] = m_r2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_press  = m_stable & ~m_new;
      m_stable = m_new;
      m_r2 = m_r1;
      m_r1 = raw;
    end
  end

  always @(negedge clk_25) begin
    if (rst_n) begin
      vectors++;
      if (btn_level !== m_stable || mif.move_valid !== m_pend ||
          busy !== (m_pend || m_cool > 0) ||
          (m_pend && mif.move_dir !== 2'(m_dir))) begin
        fails++;
        $display("FAIL model t=%0t: got lvl=%b valid=%b dir=%0d busy=%b, expected lvl=%b valid=%b dir=%0d busy=%b",
                 $time, btn_level, mif.move_valid, mif.move_dir, busy,
                 m_stable, m_pend, m_dir, (m_pend || m_cool > 0));
      end
      if (mif.move_valid) begin
        cnt_valid++;
        last_dir = int'(mif.move_dir);
      end
      if (busy) cnt_busy++;
      if (!btn_level[0]) cnt_lvl0++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk_25);
    cnt_valid = 0; cnt_busy = 0; cnt_lvl0 = 0; last_dir = -1;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25);
      if (mif.move_valid) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check({name, "_timeout"}, 0, 1);
  endtask

  int n;

  initial begin
    raw = 4'hF;
    mif.move_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25);
    check("rst_level", int'(btn_level), 15);
    check("rst_valid", int'(mif.move_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_dir",   int'(mif.move_dir), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_25);

    // Held button2: a single move, 7 cycles after the raw edge.
    clr();
    @(negedge clk_25); raw[1] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_25);
      if (mif.move_valid && n == 0) n = i;
    end
    check("t1_latency", n, 7);
    check("t1_dir", last_dir, 1);
    raw = 4'hF;
    repeat (12) @(negedge clk_25);
    check("t1_moves", cnt_valid, 1);
    check("t1_busy", cnt_busy, 1 + C);

    // Three-cycle glitch is filtered out.
    clr();
    @(negedge clk_25); raw[0] = 1'b0;
    repeat (3) @(negedge clk_25);
    raw[0] = 1'b1;
    repeat (12) @(negedge clk_25);
    check("t2_level0_low", cnt_lvl0, 0);
    check("t2_moves", cnt_valid, 0);

    // Simultaneous button1 and button4: lowest index wins.
    clr();
    @(negedge clk_25); raw = 4'b0110;
    repeat (10) @(negedge clk_25);
    check("t3_level", int'(btn_level), 6);
    check("t3_moves", cnt_valid, 1);
    check("t3_dir", last_dir, 0);
    raw = 4'hF;
    repeat (20) @(negedge clk_25);

    // Back-pressure: move held for 10 cycles of move_ready=0.
    clr();
    mif.move_ready = 1'b0;
    @(negedge clk_25); raw[2] = 1'b0;
    wait_valid("t4", n);
    repeat (10) @(negedge clk_25);
    check("t4_dir_held", int'(mif.move_dir), 2);
    mif.move_ready = 1'b1;
    repeat (12) @(negedge clk_25);
    check("t4_valid_cycles", cnt_valid, 11);
    check("t4_busy_cycles", cnt_busy, 11 + C);
    raw = 4'hF;
    repeat (12) @(negedge clk_25);

    // Press during cooldown: dropped, or queued when the queue is built in.
    clr();
    @(negedge clk_25); raw[0] = 1'b0;
    wait_valid("t5", n);
    repeat (2) @(negedge clk_25);
    raw[1] = 1'b0;
    repeat (25) @(negedge clk_25);
`ifdef MOVE_QUEUE_EN
    check("t5_moves", cnt_valid, 2);
    check("t5_last_dir", last_dir, 1);
`else
    check("t5_moves", cnt_valid, 1);
    check("t5_last_dir", last_dir, 0);
`endif
    raw = 4'hF;
    repeat (20) @(negedge clk_25);

    // Reset while a move is pending drops it.
    clr();
    mif.move_ready = 1'b0;
    @(negedge clk_25); raw[0] = 1'b0;
    wait_valid("t6", n);
    @(negedge clk_25);
    rst_n = 1'b0;
    raw = 4'hF;
    #1;
    check("t6_valid", int'(mif.move_valid), 0);
    check("t6_level", int'(btn_level), 15);
    check("t6_busy", int'(busy), 0);
    @(negedge clk_25);
    rst_n = 1'b1;
    mif.move_ready = 1'b1;
    clr();
    repeat (20) @(negedge clk_25);
    check("t6_no_move", cnt_valid, 0);

    // A fresh press after reset is issued normally.
    clr();
    @(negedge clk_25); raw[3] = 1'b0;
    repeat (12) @(negedge clk_25);
    check("t6_new_moves", cnt_valid, 1);
    check("t6_new_dir", last_dir, 3);
    raw = 4'hF;
    repeat (20) @(negedge clk_25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
